// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch PC controller: single-outstanding request/grant/response fetch with
// redirect, kill/drop handling. Optional misaligned-target trap under FETCH_PC_CTRL_MISALIGN_EN.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pc_write_i,
  input  logic        pc_src_i,
  input  logic        jalr_flag_i,
  input  logic [31:0] jalr_target_offset_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        flush_o
`ifdef FETCH_PC_CTRL_MISALIGN_EN
  ,
  output logic        misalign_err_o
`endif
);

`ifdef FETCH_PC_CTRL_MISALIGN_EN
  typedef enum logic [2:0] {StIdle, StReq, StResp, StDrop, StHalt} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StResp, StDrop} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_up_q, req_up_d;
  logic        kill_q, kill_d;

  logic [31:0] target_raw, target;
  logic        redirect, misalign, accept;

  assign target_raw = jalr_flag_i ? (jalr_target_offset_i & ~32'h1) : branch_target_i;

`ifdef FETCH_PC_CTRL_MISALIGN_EN
  assign target   = target_raw;
  assign misalign = target_raw[1];
  // A halted fetch unit no longer accepts redirects.
  assign redirect = rstn_i && pc_src_i && (state_q != StHalt);
`else
  assign target   = target_raw & ~32'h3;
  assign misalign = 1'b0;
  assign redirect = rstn_i && pc_src_i;
`endif

  assign accept = redirect && !misalign;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_up_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_up_q <= req_up_d;
      kill_q   <= kill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_up_d = req_up_q;
    kill_d   = kill_q;
    // addr_q tracks the address on the bus so the response can be tagged with it.
    if (imem_req_o) addr_d = imem_addr_o;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_req_o) begin
          if (imem_gnt_i) begin
            req_up_d = 1'b0;
            state_d  = (kill_q || redirect) ? StDrop : StResp;
          end else begin
            req_up_d = 1'b1;
            if (redirect) kill_d = 1'b1;
          end
        end
      end
      StResp: begin
        if (imem_rvalid_i) begin
          state_d = StReq;
          if (!redirect) pc_d = pc_q + 32'd4;
        end else if (redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_rvalid_i) begin
          kill_d  = 1'b0;
          state_d = StReq;
        end
      end
      default: state_d = state_q;
    endcase
    if (accept) pc_d = target;
`ifdef FETCH_PC_CTRL_MISALIGN_EN
    if (redirect && misalign) begin
      state_d  = StHalt;
      pc_d     = pc_q;
      req_up_d = 1'b0;
      kill_d   = 1'b0;
    end
`endif
  end

  always_comb begin
    imem_req_o  = (state_q == StReq) && (req_up_q || pc_write_i);
    imem_addr_o = req_up_q ? addr_q : pc_q;
    if_valid_o  = (state_q == StResp) && imem_rvalid_i && !redirect;
    if_instr_o  = if_valid_o ? imem_rdata_i : 32'h0;
    if_pc_o     = if_valid_o ? addr_q : 32'h0;
    flush_o     = redirect;
`ifdef FETCH_PC_CTRL_MISALIGN_EN
    misalign_err_o = redirect && misalign;
`endif
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: scripted memory handshake with a scoreboard of
// expected (pc, instr) pairs pushed at grant and popped when if_valid is seen.
module tb_fetch_pc_ctrl;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        pc_write_i, pc_src_i, jalr_flag_i;
  logic [31:0] jalr_target_offset_i, branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o, if_pc_o;
  logic        flush_o;
`ifdef FETCH_PC_CTRL_MISALIGN_EN
  logic        misalign_err_o;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;

  fetch_pc_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .pc_write_i(pc_write_i), .pc_src_i(pc_src_i),
    .jalr_flag_i(jalr_flag_i), .jalr_target_offset_i(jalr_target_offset_i),
    .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .flush_o(flush_o)
`ifdef FETCH_PC_CTRL_MISALIGN_EN
    , .misalign_err_o(misalign_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write_i = 1'b0; pc_src_i = 1'b0; jalr_flag_i = 1'b0;
    jalr_target_offset_i = 32'h0; branch_target_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    idle_inputs();
    pc_src_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
    total++; if (if_valid_o !== 1'b0 || if_instr_o !== 32'h0 || if_pc_o !== 32'h0) begin
      bad++; $display("FAIL rst_if: got v=%b i=%h p=%h want 0", if_valid_o, if_instr_o, if_pc_o);
    end
    total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b want 0", flush_o); end
`ifdef FETCH_PC_CTRL_MISALIGN_EN
    total++; if (misalign_err_o !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", misalign_err_o); end
`endif
    pc_src_i = 1'b0;
    pc_write_i = 1'b1;
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", imem_req_o); end
    tick();
    exp_pc = 32'h0;
  endtask

  // Back-to-back fetches with grant in the request cycle and rvalid one cycle later.
  task automatic test_seq_fetch();
    for (int k = 0; k < 4; k++) begin
      pc_write_i = 1'b1; imem_gnt_i = 1'b1; #1;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
        bad++; $display("FAIL seq_req: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
      end
      sb.push_back('{pc: exp_pc, instr: 32'h0000_0013});
      tick();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013; #1;
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL seq_resp_req: got %b want 0", imem_req_o); end
      total++;
      if (if_valid_o !== 1'b1 || sb.size() == 0) begin
        bad++; $display("FAIL seq_valid: got %b want 1 (queued %0d)", if_valid_o, sb.size());
      end else begin
        e = sb.pop_front();
        total++; if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
          bad++; $display("FAIL seq_data: got %h/%h want %h/%h", if_pc_o, if_instr_o, e.pc, e.instr);
        end
      end
      tick();
      imem_rvalid_i = 1'b0;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    pc_write_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
        bad++; $display("FAIL stall_req: got req=%b v=%b want 0 0", imem_req_o, if_valid_o);
      end
      tick();
    end
    imem_rvalid_i = 1'b0; pc_write_i = 1'b1; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
      bad++; $display("FAIL stall_go: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
    end
    tick();
    pc_write_i = 1'b0; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
      bad++; $display("FAIL stall_hold: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
    end
    imem_gnt_i = 1'b1;
    sb.push_back('{pc: exp_pc, instr: mem_data(exp_pc)});
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_data(exp_pc); #1;
    total++;
    if (if_valid_o !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL stall_valid: got %b want 1", if_valid_o);
    end else begin
      e = sb.pop_front();
      total++; if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
        bad++; $display("FAIL stall_data: got %h/%h want %h/%h", if_pc_o, if_instr_o, e.pc, e.instr);
      end
    end
    tick();
    imem_rvalid_i = 1'b0;
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_jalr_resp();
    pc_write_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; pc_src_i = 1'b1; jalr_flag_i = 1'b1; jalr_target_offset_i = 32'h0000_0101;
    #1;
    total++; if (flush_o !== 1'b1 || if_valid_o !== 1'b0) begin
      bad++; $display("FAIL jalr_flush: got flush=%b v=%b want 1 0", flush_o, if_valid_o);
    end
    tick();
    pc_src_i = 1'b0; jalr_flag_i = 1'b0; #1;
    total++; if (flush_o !== 1'b0 || imem_req_o !== 1'b0) begin
      bad++; $display("FAIL jalr_drop: got flush=%b req=%b want 0 0", flush_o, imem_req_o);
    end
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0000; #1;
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL jalr_discard: got %b want 0", if_valid_o); end
    tick();
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; exp_pc = 32'h0000_0100; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
      bad++; $display("FAIL jalr_target: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
    end
    sb.push_back('{pc: exp_pc, instr: mem_data(exp_pc)});
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_data(exp_pc); #1;
    total++;
    if (if_valid_o !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL jalr_valid: got %b want 1", if_valid_o);
    end else begin
      e = sb.pop_front();
      total++; if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
        bad++; $display("FAIL jalr_data: got %h/%h want %h/%h", if_pc_o, if_instr_o, e.pc, e.instr);
      end
    end
    tick();
    imem_rvalid_i = 1'b0;
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_branch_rvalid();
    pc_write_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0001;
    pc_src_i = 1'b1; branch_target_i = 32'h0000_0040; #1;
    total++; if (if_valid_o !== 1'b0 || flush_o !== 1'b1) begin
      bad++; $display("FAIL br_coinc: got v=%b flush=%b want 0 1", if_valid_o, flush_o);
    end
    tick();
    pc_src_i = 1'b0; imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; exp_pc = 32'h0000_0040; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
      bad++; $display("FAIL br_target: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
    end
    sb.push_back('{pc: exp_pc, instr: mem_data(exp_pc)});
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_data(exp_pc); #1;
    total++;
    if (if_valid_o !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL br_valid: got %b want 1", if_valid_o);
    end else begin
      e = sb.pop_front();
      total++; if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
        bad++; $display("FAIL br_data: got %h/%h want %h/%h", if_pc_o, if_instr_o, e.pc, e.instr);
      end
    end
    tick();
    imem_rvalid_i = 1'b0;
    exp_pc = exp_pc + 32'd4;
  endtask

  // Redirect while a request waits for grant: the request completes and its data is dropped.
  task automatic test_kill();
    logic [31:0] held;
    held = exp_pc;
    pc_write_i = 1'b1; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== held) begin
      bad++; $display("FAIL kill_raise: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, held);
    end
    tick();
    pc_src_i = 1'b1; branch_target_i = 32'h0000_0080; pc_write_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== held) begin
        bad++; $display("FAIL kill_hold: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, held);
      end
      tick();
      pc_src_i = 1'b0;
    end
    imem_gnt_i = 1'b1; #1;
    total++; if (imem_addr_o !== held) begin
      bad++; $display("FAIL kill_gnt: got addr=%h want %h", imem_addr_o, held);
    end
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0002; #1;
    total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL kill_discard: got %b want 0", if_valid_o); end
    tick();
    imem_rvalid_i = 1'b0; pc_write_i = 1'b1; imem_gnt_i = 1'b1; exp_pc = 32'h0000_0080; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
      bad++; $display("FAIL kill_target: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
    end
    sb.push_back('{pc: exp_pc, instr: mem_data(exp_pc)});
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_data(exp_pc); #1;
    total++;
    if (if_valid_o !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL kill_valid: got %b want 1", if_valid_o);
    end else begin
      e = sb.pop_front();
      total++; if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
        bad++; $display("FAIL kill_data: got %h/%h want %h/%h", if_pc_o, if_instr_o, e.pc, e.instr);
      end
    end
    tick();
    imem_rvalid_i = 1'b0;
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_wrap();
    pc_write_i = 1'b0; pc_src_i = 1'b1; branch_target_i = 32'hFFFF_FFFC; #1;
    total++; if (imem_req_o !== 1'b0 || flush_o !== 1'b1) begin
      bad++; $display("FAIL wrap_redir: got req=%b flush=%b want 0 1", imem_req_o, flush_o);
    end
    tick();
    pc_src_i = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    for (int k = 0; k < 2; k++) begin
      pc_write_i = 1'b1; imem_gnt_i = 1'b1; #1;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
        bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
      end
      sb.push_back('{pc: exp_pc, instr: mem_data(exp_pc)});
      tick();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_data(exp_pc); #1;
      total++;
      if (if_valid_o !== 1'b1 || sb.size() == 0) begin
        bad++; $display("FAIL wrap_valid: got %b want 1", if_valid_o);
      end else begin
        e = sb.pop_front();
        total++; if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
          bad++; $display("FAIL wrap_data: got %h/%h want %h/%h", if_pc_o, if_instr_o, e.pc, e.instr);
        end
      end
      tick();
      imem_rvalid_i = 1'b0;
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    pc_write_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0003;
    rstn_i = 1'b0; #1;
    total++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin
      bad++; $display("FAIL rmid_reset: got v=%b req=%b addr=%h want 0 0 0", if_valid_o, imem_req_o,
                      imem_addr_o);
    end
    tick();
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    pc_write_i = 1'b0; #1;
    total++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      bad++; $display("FAIL rmid_ignore: got v=%b req=%b want 0 0", if_valid_o, imem_req_o);
    end
    imem_rvalid_i = 1'b0; pc_write_i = 1'b1; imem_gnt_i = 1'b1; exp_pc = 32'h0; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
      bad++; $display("FAIL rmid_restart: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
    end
    sb.push_back('{pc: exp_pc, instr: 32'h0000_0013});
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013; #1;
    total++;
    if (if_valid_o !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL rmid_valid: got %b want 1", if_valid_o);
    end else begin
      e = sb.pop_front();
      total++; if (if_pc_o !== e.pc || if_instr_o !== e.instr) begin
        bad++; $display("FAIL rmid_data: got %h/%h want %h/%h", if_pc_o, if_instr_o, e.pc, e.instr);
      end
    end
    tick();
    imem_rvalid_i = 1'b0;
    exp_pc = exp_pc + 32'd4;
  endtask

`ifdef FETCH_PC_CTRL_MISALIGN_EN
  task automatic test_misalign();
    pc_write_i = 1'b0; pc_src_i = 1'b1; branch_target_i = 32'h0000_0042; #1;
    total++; if (misalign_err_o !== 1'b1 || flush_o !== 1'b1) begin
      bad++; $display("FAIL mis_pulse: got err=%b flush=%b want 1 1", misalign_err_o, flush_o);
    end
    tick();
    pc_src_i = 1'b0; pc_write_i = 1'b1; imem_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (imem_req_o !== 1'b0 || misalign_err_o !== 1'b0) begin
        bad++; $display("FAIL mis_halt: got req=%b err=%b want 0 0", imem_req_o, misalign_err_o);
      end
      tick();
    end
    imem_gnt_i = 1'b0;
  endtask
`else
  task automatic test_misalign();
    pc_write_i = 1'b0; pc_src_i = 1'b1; branch_target_i = 32'h0000_0042; #1;
    total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL align_flush: got %b want 1", flush_o); end
    tick();
    pc_src_i = 1'b0; pc_write_i = 1'b1; imem_gnt_i = 1'b1; exp_pc = 32'h0000_0040; #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
      bad++; $display("FAIL align_addr: got req=%b addr=%h want 1 %h", imem_req_o, imem_addr_o, exp_pc);
    end
    tick();
    imem_gnt_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_jalr_resp();
    test_branch_rvalid();
    test_kill();
    test_wrap();
    test_reset_mid();
    test_misalign();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
